// File: rtl/bp2wb_burst_bridge.sv
// bp2wb_burst_bridge: turns one BP-style memory command into a Wishbone B4 burst and returns one response.
// Ports:
//   clk_i, reset_n_i              clock, asynchronous active-low reset
//   cmd_*                         command channel (valid/ready, type, size, addr, payload, data)
//   resp_*                        response channel (valid/yumi, echoed header, read data, error flag)
//   adr_o, dat_o, sel_o, cyc_o,
//   stb_o, we_o, cti_o, bte_o     Wishbone master outputs
//   dat_i, ack_i, err_i, rty_i    Wishbone slave returns
module bp2wb_burst_bridge #(
    parameter int          wb_data_width_p = 64,
    parameter int          block_width_p   = 512,
    parameter int          paddr_width_p   = 40,
    parameter logic [31:0] cached_base_p   = 32'h7000_0000,
    parameter int          max_retry_p     = 4,
    parameter int          payload_width_p = 11
) (
    input  logic                                                 clk_i,
    input  logic                                                 reset_n_i,
    input  logic                                                 cmd_v_i,
    output logic                                                 cmd_ready_o,
    input  logic [1:0]                                           cmd_type_i,
    input  logic [2:0]                                           cmd_size_i,
    input  logic [paddr_width_p-1:0]                             cmd_addr_i,
    input  logic [payload_width_p-1:0]                           cmd_payload_i,
    input  logic [block_width_p-1:0]                             cmd_data_i,
    output logic                                                 resp_v_o,
    input  logic                                                 resp_yumi_i,
    output logic [1:0]                                           resp_type_o,
    output logic [2:0]                                           resp_size_o,
    output logic [paddr_width_p-1:0]                             resp_addr_o,
    output logic [payload_width_p-1:0]                           resp_payload_o,
    output logic [block_width_p-1:0]                             resp_data_o,
    output logic                                                 resp_err_o,
    output logic [paddr_width_p-$clog2(wb_data_width_p/8)-1:0]   adr_o,
    output logic [wb_data_width_p-1:0]                           dat_o,
    input  logic [wb_data_width_p-1:0]                           dat_i,
    output logic [wb_data_width_p/8-1:0]                         sel_o,
    output logic                                                 cyc_o,
    output logic                                                 stb_o,
    output logic                                                 we_o,
    output logic [2:0]                                           cti_o,
    output logic [1:0]                                           bte_o,
    input  logic                                                 ack_i,
    input  logic                                                 err_i,
    input  logic                                                 rty_i
);
    localparam int bus_bytes_lp = wb_data_width_p / 8;
    localparam int lg_bus_lp    = $clog2(bus_bytes_lp);
    localparam int beats_lp     = block_width_p / wb_data_width_p;
    localparam int beat_w_lp    = $clog2(beats_lp + 1);
    localparam int retry_w_lp   = $clog2(max_retry_p + 1);
    localparam int wadr_w_lp    = paddr_width_p - lg_bus_lp;

    typedef enum logic [1:0] {IDLE, BUS, BACKOFF, RESP} state_t;
    state_t state_r, state_n;

    logic [1:0]                 type_r;
    logic [2:0]                 size_r;
    logic [paddr_width_p-1:0]   addr_r;
    logic [payload_width_p-1:0] payload_r;
    logic [block_width_p-1:0]   data_r, rdata_r, rd_m;
    logic [beat_w_lp-1:0]       beat_r, n_r, cmd_n;
    logic [retry_w_lp-1:0]      retry_r;
    logic                       err_r, cached_r, cmd_cached, accept, in_bus, last, narrow, retry_max;
    logic [lg_bus_lp-1:0]       off;
    logic [wadr_w_lp-1:0]       wbase;
    logic [bus_bytes_lp-1:0]    sel_m;
    logic [wb_data_width_p-1:0] dat_m;

    assign cmd_ready_o = state_r == IDLE;
    assign resp_v_o    = state_r == RESP;
    assign in_bus      = state_r == BUS;
    assign accept      = cmd_v_i & cmd_ready_o;
    assign cmd_cached  = cmd_addr_i >= paddr_width_p'(cached_base_p);
    assign cmd_n       = cmd_cached ? beat_w_lp'(beats_lp)
                       : (8 << cmd_size_i) < wb_data_width_p ? beat_w_lp'(1)
                       : beat_w_lp'((8 << cmd_size_i) / wb_data_width_p);
    assign off         = addr_r[lg_bus_lp-1:0];
    assign last        = beat_r == n_r - beat_w_lp'(1);
    assign narrow      = !cached_r && (int'(size_r) < lg_bus_lp);
    assign retry_max   = retry_r == retry_w_lp'(max_retry_p);
    // Cached bursts start on a block boundary, so clear the in-block word index too.
    assign wbase       = addr_r[paddr_width_p-1:lg_bus_lp] & ~(cached_r ? wadr_w_lp'(beats_lp - 1) : '0);

    assign resp_type_o    = type_r;
    assign resp_size_o    = size_r;
    assign resp_addr_o    = addr_r;
    assign resp_payload_o = payload_r;
    assign resp_err_o     = err_r;
    assign resp_data_o    = type_r[0] ? '0 : cached_r ? rdata_r : (rdata_r >> {off, 3'b000}) & rd_m;

    // Byte/bit masks covering 2^size bytes of the access.
    always_comb begin
        sel_m = '0;
        dat_m = '0;
        rd_m  = '0;
        for (int i = 0; i < bus_bytes_lp; i++) sel_m[i] = i < (1 << size_r);
        for (int i = 0; i < wb_data_width_p; i++) dat_m[i] = i < (8 << size_r);
        for (int i = 0; i < block_width_p; i++) rd_m[i] = i < (8 << size_r);
    end

    always_comb begin
        state_n = state_r;
        cyc_o   = in_bus;
        stb_o   = in_bus;
        we_o    = in_bus & type_r[0];
        cti_o   = !in_bus || n_r == beat_w_lp'(1) ? 3'b000 : last ? 3'b111 : 3'b010;
        bte_o   = 2'b00;
        adr_o   = in_bus ? wbase + wadr_w_lp'(beat_r) : '0;
        sel_o   = !in_bus ? '0 : narrow ? sel_m << off : '1;
        dat_o   = !in_bus ? '0
                : narrow ? (data_r[wb_data_width_p-1:0] & dat_m) << {off, 3'b000}
                : data_r[beat_r*wb_data_width_p +: wb_data_width_p];
        if (accept)
            state_n = BUS;
        else if (in_bus && (err_i || (ack_i && last) || (!ack_i && rty_i && retry_max)))
            state_n = RESP;
        else if (in_bus && !ack_i && rty_i)
            state_n = BACKOFF;
        else if (state_r == BACKOFF)
            state_n = BUS;
        else if (resp_v_o && resp_yumi_i)
            state_n = IDLE;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_r <= IDLE;
        else            state_r <= state_n;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            type_r    <= '0;
            size_r    <= '0;
            addr_r    <= '0;
            payload_r <= '0;
            data_r    <= '0;
            rdata_r   <= '0;
            beat_r    <= '0;
            n_r       <= '0;
            retry_r   <= '0;
            err_r     <= 1'b0;
            cached_r  <= 1'b0;
        end else if (accept) begin
            type_r    <= cmd_type_i;
            size_r    <= cmd_size_i;
            addr_r    <= cmd_addr_i;
            payload_r <= cmd_payload_i;
            data_r    <= cmd_data_i;
            rdata_r   <= '0;
            beat_r    <= '0;
            n_r       <= cmd_n;
            retry_r   <= '0;
            err_r     <= 1'b0;
            cached_r  <= cmd_cached;
        end else if (in_bus) begin
            // err_i wins, then ack_i; a retry beyond the budget becomes an error.
            if (err_i || (!ack_i && rty_i && retry_max)) begin
                err_r <= 1'b1;
            end else if (ack_i) begin
                if (!type_r[0]) rdata_r[beat_r*wb_data_width_p +: wb_data_width_p] <= dat_i;
                beat_r  <= beat_r + beat_w_lp'(1);
                retry_r <= '0;
            end else if (rty_i) begin
                retry_r <= retry_r + retry_w_lp'(1);
            end
        end
    end
endmodule
